// File: rtl/sad_popcount.sv
// Sequential Hamming-weight reducer for the SAD mismatch vector: CHUNK bits per cycle.
// Optional best-match tracking is built when SAD_POPCOUNT_MIN_TRACK_EN is defined.
module sad_popcount #(
    parameter int unsigned WIDTH = 4000,
    parameter int unsigned CHUNK = 200,
    parameter int unsigned CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] sad_out
`ifdef SAD_POPCOUNT_MIN_TRACK_EN
    ,
    input  logic             frame_start,
    output logic [CNT_W-1:0] min_sad,
    output logic [15:0]      min_idx
`endif
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned IDX_W  = 16;

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("sad_popcount: WIDTH must be a multiple of CHUNK");
        end
        if (CNT_W < $clog2(WIDTH + 1)) begin : g_bad_cnt_w
            $error("sad_popcount: CNT_W too narrow for WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  shreg;
    logic [CNT_W-1:0]  acc;
    logic [CIDX_W-1:0] cnt;
    logic [CNT_W-1:0]  chunk_sum;
    logic [CNT_W-1:0]  acc_next;

    // Per-chunk popcount; synthesis balances this sum into an adder tree.
    function automatic logic [CNT_W-1:0] popcount(input logic [CHUNK-1:0] v);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            s = s + CNT_W'(v[i]);
        end
        return s;
    endfunction

    assign chunk_sum = popcount(shreg[CHUNK-1:0]);
    assign acc_next  = acc + chunk_sum;

    // Ready follows ena directly in IDLE so a stalled block never advertises space.
    assign in_ready = (state == IDLE) && ena && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            sad_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && ena) begin
                        shreg <= d_in;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (ena) begin
                        acc   <= acc_next;
                        shreg <= shreg >> CHUNK;
                        cnt   <= cnt + CIDX_W'(1);
                        if (cnt == CIDX_W'(NCHUNK - 1)) begin
                            sad_out   <= acc_next;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SAD_POPCOUNT_MIN_TRACK_EN
    logic             out_hs;
    logic [IDX_W-1:0] res_idx;

    assign out_hs = (state == DONE) && out_ready;

    // Frame clear has priority over recording a coincident result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_sad <= '1;
            min_idx <= '0;
            res_idx <= '0;
        end else if (frame_start) begin
            min_sad <= '1;
            min_idx <= '0;
            res_idx <= '0;
        end else if (out_hs) begin
            if (sad_out < min_sad) begin
                min_sad <= sad_out;
                min_idx <= res_idx;
            end
            res_idx <= res_idx + IDX_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_sad_popcount.sv
// Directed bench for sad_popcount at default parameters; also covers min tracking
// when built with SAD_POPCOUNT_MIN_TRACK_EN.
module tb_sad_popcount;

    localparam int unsigned WIDTH = 4000;
    localparam int unsigned CHUNK = 200;
    localparam int unsigned CNT_W = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d_in;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] sad_out;
`ifdef SAD_POPCOUNT_MIN_TRACK_EN
    logic             frame_start;
    logic [CNT_W-1:0] min_sad;
    logic [15:0]      min_idx;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sad_popcount #(.WIDTH(WIDTH), .CHUNK(CHUNK), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d_in      (d_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sad_out   (sad_out)
`ifdef SAD_POPCOUNT_MIN_TRACK_EN
        ,
        .frame_start (frame_start),
        .min_sad     (min_sad),
        .min_idx     (min_idx)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] low_ones(input int n);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Present a vector and return one time unit after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] v);
        int w;
        w = 0;
        while (!in_ready && w < 60) begin
            tick();
            w++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        d_in     = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    initial begin
        int               lat;
        logic [WIDTH-1:0] v;

        rst = 1'b1; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1; d_in = '0;
`ifdef SAD_POPCOUNT_MIN_TRACK_EN
        frame_start = 1'b0;
`endif
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sad_out", 32'(sad_out), 32'd0);
`ifdef SAD_POPCOUNT_MIN_TRACK_EN
        check("rst_min_sad", 32'(min_sad), 32'd4095);
        check("rst_min_idx", 32'(min_idx), 32'd0);
`endif
        tick(); tick();
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // All zeros
        send('0);
        wait_out(lat);
        check("zero_latency", 32'(lat), 32'd20);
        check("zero_sad", 32'(sad_out), 32'd0);
        tick();
        check("zero_hs_out_valid", 32'(out_valid), 32'd0);

        // All ones
        send('1);
        wait_out(lat);
        check("ones_latency", 32'(lat), 32'd20);
        check("ones_sad", 32'(sad_out), 32'd4000);
        tick();

        // Single bit at each end
        v = '0; v[0] = 1'b1;
        send(v);
        wait_out(lat);
        check("bit0_sad", 32'(sad_out), 32'd1);
        tick();
        v = '0; v[WIDTH-1] = 1'b1;
        send(v);
        wait_out(lat);
        check("bit3999_sad", 32'(sad_out), 32'd1);
        tick();

        // Alternating pattern
        v = {(WIDTH/2){2'b01}};
        send(v);
        wait_out(lat);
        check("alt_sad", 32'(sad_out), 32'd2000);
        tick();

        // ena stall of 3 cycles mid-accumulation
        send(low_ones(33));
        repeat (5) tick();
        ena = 1'b0;
        repeat (3) tick();
        check("stall_no_out", 32'(out_valid), 32'd0);
        ena = 1'b1;
        wait_out(lat);
        check("stall_latency", 32'(lat + 8), 32'd23);
        check("stall_sad", 32'(sad_out), 32'd33);
        tick();

        // ena low in IDLE blocks acceptance
        ena = 1'b0; in_valid = 1'b1; d_in = '1;
        #1;
        check("ena0_in_ready", 32'(in_ready), 32'd0);
        repeat (3) tick();
        in_valid = 1'b0;
        ena = 1'b1;
        #1;
        check("ena0_not_accepted", 32'(in_ready), 32'd1);

        // Back-pressure in DONE and a new vector offered during DONE
        out_ready = 1'b0;
        send(low_ones(5));
        wait_out(lat);
        in_valid = 1'b1; d_in = '1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sad", 32'(sad_out), 32'd5);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release", 32'(out_valid), 32'd0);
        check("bp_idle_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        check("after_done_latency", 32'(lat), 32'd20);
        check("after_done_sad", 32'(sad_out), 32'd4000);
        tick();

        // Reset mid-accumulation
        send('1);
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sad", 32'(sad_out), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) check("midrst_spurious_valid", 32'(out_valid), 32'd0);
        end
        v = '0;
        v[0] = 1'b1; v[1] = 1'b1; v[2] = 1'b1; v[500] = 1'b1;
        v[1000] = 1'b1; v[2000] = 1'b1; v[3999] = 1'b1;
        send(v);
        wait_out(lat);
        check("postrst_latency", 32'(lat), 32'd20);
        check("postrst_sad", 32'(sad_out), 32'd7);
        tick();

`ifdef SAD_POPCOUNT_MIN_TRACK_EN
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        send(low_ones(100)); wait_out(lat); tick();
        send(low_ones(50));  wait_out(lat); tick();
        send(low_ones(70));  wait_out(lat); tick();
        send(low_ones(50));  wait_out(lat); tick();
        check("min_sad", 32'(min_sad), 32'd50);
        check("min_idx", 32'(min_idx), 32'd1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("frame_min_sad", 32'(min_sad), 32'd4095);
        check("frame_min_idx", 32'(min_idx), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
